// File: rtl/twiddle_mult_pipe.sv
// -----------------------------------------------------------------------------
// twiddle_mult_pipe
//
// Three-stage pipelined complex multiplier for the FFT butterfly datapath:
//   (x_r + j*x_i) * (w_r + j*w_i), optionally with the twiddle conjugated
// (IFFT). The full-precision product is rounded (half away from zero) or
// truncated (floor), arithmetically shifted right by SHIFT and reduced to
// OUT_W bits per component.
//
// Optional build macro:
//   TWM_SAT_EN  defined   -> out-of-range results clamp to the OUT_W limits
//               undefined -> wrap-style reduction {sign, low OUT_W-1 bits}
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  input handshake (in_ready is the global advance)
//   x_r, x_i           signed data sample, XW bits per component
//   w_r, w_i           signed twiddle, WW bits per component
//   conj               1 = multiply by (w_r - j*w_i); travels with the sample
//   rnd                1 = round half away from zero, 0 = floor; travels
//   out_valid/out_ready output handshake
//   out_r, out_i       signed result, OUT_W bits per component
//
// Pipeline: S1 registers operands (w_i pre-negated for conj), S2 registers
// the four partial products, S3 combines/rounds/shifts/reduces and holds the
// output. All stages advance together on adv = !out_valid || out_ready.
// -----------------------------------------------------------------------------
module twiddle_mult_pipe #(
    parameter int XW    = 9,
    parameter int WW    = 10,
    parameter int SHIFT = 3,
    parameter int OUT_W = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XW-1:0]    x_r,
    input  logic [XW-1:0]    x_i,
    input  logic [WW-1:0]    w_r,
    input  logic [WW-1:0]    w_i,
    input  logic             conj,
    input  logic             rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_r,
    output logic [OUT_W-1:0] out_i
);

    // Full product width; one extra twiddle bit keeps -(-2^(WW-1)) exact.
    localparam int PW = XW + WW + 1;
    localparam int WE = WW + 1;

    // Rounding offset 2^(SHIFT-1) at full product width.
    localparam logic signed [PW-1:0] HALF = {{(PW-1){1'b0}}, 1'b1} << (SHIFT - 1);

    // ------------------------------------------------------------------
    // Global advance and stage valid bits (index = stage number)
    // ------------------------------------------------------------------
    logic       adv;
    logic [3:1] vld_q;

    assign adv       = !vld_q[3] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[2:1], in_valid};
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: operand capture. The conjugate is applied here by negating
    // the sign-extended w_i so S2 never needs to know about conj.
    // ------------------------------------------------------------------
    logic signed [WE-1:0] w_i_ext;
    logic signed [WE-1:0] w_i_eff;

    assign w_i_ext = {w_i[WW-1], w_i};
    assign w_i_eff = conj ? -w_i_ext : w_i_ext;

    logic signed [XW-1:0] x_r1_q, x_i1_q;
    logic signed [WE-1:0] w_r1_q, w_i1_q;
    logic                 rnd1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r1_q <= '0;
            x_i1_q <= '0;
            w_r1_q <= '0;
            w_i1_q <= '0;
            rnd1_q <= 1'b0;
        end else if (adv) begin
            x_r1_q <= x_r;
            x_i1_q <= x_i;
            w_r1_q <= {w_r[WW-1], w_r};
            w_i1_q <= w_i_eff;
            rnd1_q <= rnd;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: partial products, each exact in PW bits.
    // ------------------------------------------------------------------
    logic signed [PW-1:0] pp_rr_d, pp_ii_d, pp_ri_d, pp_ir_d;

    assign pp_rr_d = PW'(x_r1_q) * PW'(w_r1_q);
    assign pp_ii_d = PW'(x_i1_q) * PW'(w_i1_q);
    assign pp_ri_d = PW'(x_r1_q) * PW'(w_i1_q);
    assign pp_ir_d = PW'(x_i1_q) * PW'(w_r1_q);

    logic signed [PW-1:0] pp_rr_q, pp_ii_q, pp_ri_q, pp_ir_q;
    logic                 rnd2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_rr_q <= '0;
            pp_ii_q <= '0;
            pp_ri_q <= '0;
            pp_ir_q <= '0;
            rnd2_q  <= 1'b0;
        end else if (adv) begin
            pp_rr_q <= pp_rr_d;
            pp_ii_q <= pp_ii_d;
            pp_ri_q <= pp_ri_d;
            pp_ir_q <= pp_ir_d;
            rnd2_q  <= rnd1_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: combine, round, shift, reduce.
    // Products are bounded by 2^(XW+WW-2) in magnitude, so the sums and the
    // rounding offset stay well inside PW bits.
    // ------------------------------------------------------------------
    logic signed [PW-1:0] y_r, y_i;
    logic signed [PW-1:0] y_r_rnd, y_i_rnd;
    logic signed [PW-1:0] sh_r, sh_i;

    assign y_r = pp_rr_q - pp_ii_q;
    assign y_i = pp_ri_q + pp_ir_q;

    // Half away from zero: bias towards the sign before the floor shift.
    assign y_r_rnd = !rnd2_q ? y_r : (y_r[PW-1] ? y_r - HALF : y_r + HALF);
    assign y_i_rnd = !rnd2_q ? y_i : (y_i[PW-1] ? y_i - HALF : y_i + HALF);

    assign sh_r = y_r_rnd >>> SHIFT;
    assign sh_i = y_i_rnd >>> SHIFT;

    logic [OUT_W-1:0] red_r, red_i;

`ifdef TWM_SAT_EN
    localparam logic signed [PW-1:0] SAT_MAX =
        {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN =
        {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    assign red_r = (sh_r > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                   (sh_r < SAT_MIN) ? SAT_MIN[OUT_W-1:0] : sh_r[OUT_W-1:0];
    assign red_i = (sh_i > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                   (sh_i < SAT_MIN) ? SAT_MIN[OUT_W-1:0] : sh_i[OUT_W-1:0];
`else
    // Keep the true sign, drop the intermediate high bits.
    assign red_r = {sh_r[PW-1], sh_r[OUT_W-2:0]};
    assign red_i = {sh_i[PW-1], sh_i[OUT_W-2:0]};

    // Dropped high bits are intentionally discarded in wrap mode.
    logic sh_unused;
    assign sh_unused = ^{sh_r[PW-2:OUT_W-1], sh_i[PW-2:OUT_W-1]};
`endif

    logic [OUT_W-1:0] out_r_q, out_i_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r_q <= '0;
            out_i_q <= '0;
        end else if (adv) begin
            out_r_q <= red_r;
            out_i_q <= red_i;
        end
    end

    assign out_r = out_r_q;
    assign out_i = out_i_q;

endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// -----------------------------------------------------------------------------
// Bench for twiddle_mult_pipe. Expected results come from a plain-integer
// model of the complex multiply (computed when a sample is accepted) queued in
// acceptance order; one negedge process checks every consumed output, output
// stability under stall and the in_ready rule.
// -----------------------------------------------------------------------------
module tb_twiddle_mult_pipe;

    localparam int XW    = 9;
    localparam int WW    = 10;
    localparam int SHIFT = 3;
    localparam int OUT_W = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [XW-1:0]    x_r = '0, x_i = '0;
    logic signed [WW-1:0]    w_r = '0, w_i = '0;
    logic                    conj = 1'b0, rnd = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic signed [OUT_W-1:0] out_r, out_i;

    twiddle_mult_pipe #(.XW(XW), .WW(WW), .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_r       (x_r),
        .x_i       (x_i),
        .w_r       (w_r),
        .w_i       (w_i),
        .conj      (conj),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i)
    );

    typedef struct {
        int r;
        int i;
    } res_t;

    res_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // ---------------- reference model ----------------
    function automatic int reduce_ref(input longint y, input bit rn);
        longint v;
        longint s;
        longint lim;
        longint low;
        v   = y;
        lim = longint'(1) << (OUT_W - 1);
        if (rn) v = (v >= 0) ? v + (longint'(1) << (SHIFT - 1))
                             : v - (longint'(1) << (SHIFT - 1));
        s = v >>> SHIFT;
`ifdef TWM_SAT_EN
        if (s > lim - 1) s = lim - 1;
        else if (s < -lim) s = -lim;
        return int'(s);
`else
        low = s & (lim - 1);
        return (s < 0) ? int'(low - lim) : int'(low);
`endif
    endfunction

    function automatic res_t model(input int xr, input int xi, input int wr,
                                   input int wi, input bit cj, input bit rn);
        res_t   res;
        int     wie;
        longint yr, yi;
        wie   = cj ? -wi : wi;
        yr    = longint'(xr) * wr - longint'(xi) * wie;
        yi    = longint'(xr) * wie + longint'(xi) * wr;
        res.r = reduce_ref(yr, rn);
        res.i = reduce_ref(yi, rn);
        return res;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    bit                      prev_stall = 1'b0;
    logic signed [OUT_W-1:0] hold_r, hold_i;

    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_r", out_r, hold_r);
                check("hold_i", out_i, hold_i);
            end
            check("in_ready_rule", in_ready, (!out_valid || out_ready) ? 1 : 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got (%0d,%0d), expected none", out_r, out_i);
                end else begin
                    e = exp_q.pop_front();
                    check("out_r", out_r, e.r);
                    check("out_i", out_i, e.i);
                end
            end
            prev_stall = out_valid && !out_ready;
            hold_r     = out_r;
            hold_i     = out_i;
            if (in_valid && in_ready)
                exp_q.push_back(model(x_r, x_i, w_r, w_i, conj, rnd));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_random();
        x_r  = XW'(int'($urandom_range(0, 511)) - 256);
        x_i  = XW'(int'($urandom_range(0, 511)) - 256);
        w_r  = WW'(int'($urandom_range(0, 1023)) - 512);
        w_i  = WW'(int'($urandom_range(0, 1023)) - 512);
        // bias some samples towards the extreme corners
        if ($urandom_range(0, 7) == 0) begin x_r = -256; w_i = -512; end
        if ($urandom_range(0, 7) == 0) begin x_i = -256; w_r = -512; end
        conj     = $urandom_range(0, 1) == 1;
        rnd      = $urandom_range(0, 1) == 1;
        in_valid = 1'b1;
    endtask

    // Single sample into an empty pipeline; checks latency and literal result.
    task automatic direct(input string name, input int xr, input int xi, input int wr,
                          input int wi, input bit cj, input bit rn,
                          input int er, input int ei);
        res_t m;
        int   n;
        m = model(xr, xi, wr, wi, cj, rn);
        check({name, "_model_r"}, m.r, er);
        check({name, "_model_i"}, m.i, ei);
        out_ready = 1'b1;
        x_r = XW'(xr); x_i = XW'(xi); w_r = WW'(wr); w_i = WW'(wi);
        conj = cj; rnd = rn; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        check({name, "_latency"}, n, 3);
        check({name, "_r"}, out_r, er);
        check({name, "_i"}, out_i, ei);
        @(posedge clk); #1;
    endtask

    // mode 0: continuous input, out_ready low in cycles 4..8
    // mode 1: random input gaps and random back-pressure
    task automatic stream(input int n, input int mode, input string tag);
        int sent;
        int cyc;
        bit acc;
        bit saw_block;
        sent = 0; cyc = 0; saw_block = 1'b0;
        while ((sent < n || exp_q.size() != 0) && cyc < 4000) begin
            if (mode == 0) out_ready = !(cyc >= 4 && cyc <= 8);
            else           out_ready = ($urandom_range(0, 9) < 7);
            if (!in_valid && sent < n && (mode == 0 || $urandom_range(0, 9) < 7))
                drive_random();
            @(negedge clk);
            acc = in_valid && in_ready;
            if (in_valid && !in_ready) saw_block = 1'b1;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            cyc++;
        end
        out_ready = 1'b1;
        check({tag, "_sent"}, sent, n);
        check({tag, "_drained"}, exp_q.size(), 0);
        if (mode == 0) check({tag, "_in_ready_dropped"}, saw_block, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_i", out_i, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        direct("basic",    100, -50, 256, 0, 1'b0, 1'b0, 3200, -1600);
        direct("rnd_pos1",   4,   0,   3, 0, 1'b0, 1'b1,    2,     0);
        direct("rnd_pos0",   4,   0,   3, 0, 1'b0, 1'b0,    1,     0);
        direct("rnd_neg1",  -4,   0,   3, 0, 1'b0, 1'b1,   -2,     0);
        direct("rnd_neg0",  -4,   0,   3, 0, 1'b0, 1'b0,   -2,     0);
        direct("conj1",      8,   8,   0, 16, 1'b1, 1'b0,  16,   -16);
        direct("conj0",      8,   8,   0, 16, 1'b0, 1'b0, -16,    16);
`ifdef TWM_SAT_EN
        direct("ovf", -256, -256, -512, 511, 1'b0, 1'b0, 16383, 32);
`else
        direct("ovf", -256, -256, -512, 511, 1'b0, 1'b0, 16352, 32);
`endif
        // conjugating the most negative twiddle must not overflow
        direct("conj_min", -256, 0, 0, -512, 1'b1, 1'b0, 0, -16384);

        stream(8, 0, "bp");
        stream(300, 1, "rand");

        // reset with three samples in flight
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_random();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_r", out_r, 0);
        check("midrst_out_i", out_i, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("postrst_idle", out_valid, 0);
        end
        @(posedge clk); #1;
        stream(20, 1, "postrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
